// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and direction encoding for the counter and its decode stage.
// Helpers work on zero-extended values up to FN_W bits; callers cast back to their own width.
package gray_counter_pkg;

   localparam int FN_W = 32;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin_v);
      return bin_v ^ (bin_v >> 1);
   endfunction

   // Prefix XOR from the MSB down; leading zeros of a narrower value decode to zeros.
   function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray_v);
      logic [FN_W-1:0] bin_v;
      bin_v[FN_W-1] = gray_v[FN_W-1];
      for (int i = FN_W - 2; i >= 0; i--) begin
         bin_v[i] = bin_v[i+1] ^ gray_v[i];
      end
      return bin_v;
   endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Generic-width combinational Gray-to-binary decoder (prefix XOR from the MSB down).
// Shared with the downstream decode stage.
module gray2bin_n #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the parity of all Gray bits at or above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load, wrap/saturate ends,
// terminal-count pulse and saturation level. WIDTH is limited to 2..32.
module gray_counter
   import gray_counter_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_g,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] b,
   output logic             tc,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_B  = '1;
   localparam logic [WIDTH-1:0] ZERO_B = '0;

   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_nxt;
   logic [WIDTH-1:0] g_nxt;
   logic [WIDTH-1:0] load_b;
   logic             tc_nxt;
   logic             sat_nxt;

   gray2bin_n #(.WIDTH(WIDTH)) u_load_dec (
      .gray (load_g),
      .bin  (load_b)
   );

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      b_nxt   = b_q;
      tc_nxt  = 1'b0;
      sat_nxt = sat;
      if (load) begin
         b_nxt = load_b;
      end else if (en) begin
         if (up_dn == DIR_UP) begin
            if (b_q == MAX_B) begin
               if (WRAP) begin
                  b_nxt  = ZERO_B;
                  tc_nxt = 1'b1;
               end
            end else begin
               b_nxt  = b_q + 1'b1;
               tc_nxt = !WRAP && (b_nxt == MAX_B);
            end
         end else begin
            if (b_q == ZERO_B) begin
               if (WRAP) begin
                  b_nxt  = MAX_B;
                  tc_nxt = 1'b1;
               end
            end else begin
               b_nxt  = b_q - 1'b1;
               tc_nxt = !WRAP && (b_nxt == ZERO_B);
            end
         end
      end
      // Saturation is only re-evaluated when the register is written; a plain hold keeps it.
      if (load || en) begin
         sat_nxt = !WRAP && ((b_nxt == ZERO_B) || (b_nxt == MAX_B));
      end
   end

   // Gray is formed from the next binary value so g and b land on the same edge.
   assign g_nxt = WIDTH'(bin2gray(FN_W'(b_nxt)));

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q <= '0;
         g   <= '0;
         tc  <= 1'b0;
         sat <= 1'b0;
      end else begin
         b_q <= b_nxt;
         g   <= g_nxt;
         tc  <= tc_nxt;
         sat <= sat_nxt;
      end
   end

   assign b = b_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench: a wrapping and a saturating counter driven in parallel and
// compared every cycle against an integer reference model.
module tb_gray_counter;

   localparam int W    = 5;
   localparam int MAXV = (1 << W) - 1;
   localparam int MODV = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_g;

   logic [W-1:0] g_w, b_w, g_s, b_s;
   logic         tc_w, sat_w, tc_s, sat_s;

   int total = 0;
   int bad   = 0;

   // Reference state per instance: index 0 wraps, index 1 saturates.
   int mv[2];
   int mtc[2];
   int msat[2];

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_g(load_g),
      .g(g_w), .b(b_w), .tc(tc_w), .sat(sat_w)
   );

   gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_g(load_g),
      .g(g_s), .b(b_s), .tc(tc_s), .sat(sat_s)
   );

   function automatic int to_gray(input int v);
      return v ^ (v >> 1);
   endfunction

   // Decode by search: the value whose Gray code matches.
   function automatic int from_gray(input int gv);
      for (int v = 0; v <= MAXV; v++) begin
         if (to_gray(v) == gv) return v;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_g_wrap"},   32'(g_w),   to_gray(mv[0]));
      check({tag, "_b_wrap"},   32'(b_w),   mv[0]);
      check({tag, "_tc_wrap"},  32'(tc_w),  mtc[0]);
      check({tag, "_sat_wrap"}, 32'(sat_w), msat[0]);
      check({tag, "_g_sat"},    32'(g_s),   to_gray(mv[1]));
      check({tag, "_b_sat"},    32'(b_s),   mv[1]);
      check({tag, "_tc_sat"},   32'(tc_s),  mtc[1]);
      check({tag, "_sat_sat"},  32'(sat_s), msat[1]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k]   = 0;
         mtc[k]  = 0;
         msat[k] = 0;
      end
   endtask

   task automatic model_step(input bit ld, input int lg, input bit e, input bit u);
      bit wrap;
      int nv;
      int t;
      for (int k = 0; k < 2; k++) begin
         wrap = (k == 0);
         nv   = mv[k];
         t    = 0;
         if (ld) begin
            nv = from_gray(lg);
         end else if (e) begin
            if (u) begin
               if (wrap) begin
                  nv = (mv[k] + 1) % MODV;
                  t  = (mv[k] == MAXV);
               end else begin
                  nv = (mv[k] < MAXV) ? mv[k] + 1 : MAXV;
                  t  = (nv != mv[k]) && (nv == MAXV);
               end
            end else begin
               if (wrap) begin
                  nv = (mv[k] + MAXV) % MODV;
                  t  = (mv[k] == 0);
               end else begin
                  nv = (mv[k] > 0) ? mv[k] - 1 : 0;
                  t  = (nv != mv[k]) && (nv == 0);
               end
            end
         end
         if (ld || e) msat[k] = !wrap && (nv == 0 || nv == MAXV);
         mtc[k] = t;
         mv[k]  = nv;
      end
   endtask

   // One clocked step: drive, advance model at the edge, sample 1 time unit later.
   task automatic step(input string tag, input bit ld, input int lg, input bit e, input bit u);
      logic [W-1:0] pg_w, pg_s;
      int           pv_s;
      load   = ld;
      load_g = W'(lg);
      en     = e;
      up_dn  = u;
      pg_w   = g_w;
      pg_s   = g_s;
      pv_s   = mv[1];
      @(posedge clk);
      model_step(ld, lg, e, u);
      #1;
      check_all(tag);
      if (!ld && e) begin
         check({tag, "_hop_wrap"}, 32'($countones(g_w ^ pg_w)), 1);
         check({tag, "_hop_sat"},  32'($countones(g_s ^ pg_s)), (mv[1] != pv_s) ? 1 : 0);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      up_dn  = 1'b1;
      load   = 1'b0;
      load_g = '0;
      model_reset();
      #12;
      check_all("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Count up through a full cycle and past the wrap point.
      for (int i = 1; i <= 33; i++) begin
         step("up", 1'b0, 0, 1'b1, 1'b1);
         if (i == 31) begin
            check("up31_g", 32'(g_w), 16);
            check("up31_b", 32'(b_w), 31);
         end
         if (i == 32) begin
            check("wrap_g", 32'(g_w), 0);
            check("wrap_tc", 32'(tc_w), 1);
         end
      end

      // Down from zero: wrap to max, then one further step.
      apply_reset();
      step("dn_wrap", 1'b0, 0, 1'b1, 1'b0);
      check("dn_wrap_g", 32'(g_w), 16);
      check("dn_wrap_tc", 32'(tc_w), 1);
      step("dn_next", 1'b0, 0, 1'b1, 1'b0);
      check("dn_next_g", 32'(g_w), 17);
      check("dn_next_b", 32'(b_w), 30);

      // Load wins over enable, then count up from the loaded value.
      step("ld_en", 1'b1, 5'b01101, 1'b1, 1'b1);
      check("ld_en_b", 32'(b_w), 9);
      step("ld_up", 1'b0, 0, 1'b1, 1'b1);
      check("ld_up_g", 32'(g_w), 15);

      // Saturation at max, release downward, then land on zero and hold.
      step("ld_max", 1'b1, 5'b10000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("sat_hi", 1'b0, 0, 1'b1, 1'b1);
      check("sat_hi_sat", 32'(sat_s), 1);
      step("sat_rel", 1'b0, 0, 1'b1, 1'b0);
      check("sat_rel_g", 32'(g_s), 17);
      step("ld_one", 1'b1, 5'b00001, 1'b0, 1'b0);
      step("sat_lo", 1'b0, 0, 1'b1, 1'b0);
      check("sat_lo_tc", 32'(tc_s), 1);
      for (int i = 0; i < 2; i++) step("sat_lo_hold", 1'b0, 0, 1'b1, 1'b0);
      step("idle", 1'b0, 0, 1'b0, 1'b1);

      // Asynchronous reset between edges, then resume counting.
      step("ld_mid", 1'b1, 5'b01010, 1'b0, 1'b1);
      step("hold_mid", 1'b0, 0, 1'b0, 1'b1);
      en    = 1'b1;
      up_dn = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b0, 0, 1'b1, 1'b1);
      check("post_rst_g", 32'(g_w), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step("rnd", ($urandom_range(0, 7) == 0), int'($urandom_range(0, MAXV)),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
